// File: rtl/vga_capture_stream.sv
//------------------------------------------------------------------------------
// vga_capture_stream
//
// Captures the VGA generator's output bus (sync and colour pins) into a small
// first-word-fall-through FIFO and streams the samples out on a valid/ready
// port. A capture is started by a one-cycle arm pulse. It can start at once or
// wait for the vsync assertion edge. It takes 'length' samples, one every
// decim+1 cycles, and then drains the FIFO before pulsing done. Samples that
// find the FIFO full are dropped, and the sticky overflow flag records this.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   data_in    display bus, sampled every cycle
//   arm        one-cycle start pulse (only honoured while idle)
//   abort      cancel any capture and flush the FIFO
//   trig_mode  0 = trigger immediately, 1 = trigger on vsync assertion edge
//   length     number of samples to take (latched on arm)
//   decim      sample every decim+1 cycles (latched on arm)
//   m_data     output word
//   m_last     word holds sample index length-1
//   m_valid    output word available
//   m_ready    consumer accepts the word
//   busy       high whenever not idle
//   done       one-cycle completion pulse
//   overflow   sticky: at least one sample was dropped since the last arm
//------------------------------------------------------------------------------
module vga_capture_stream #(
    parameter int   DATA_W    = 16,
    parameter int   DEPTH     = 16,
    parameter int   CNT_W     = 20,
    parameter int   VSYNC_BIT = 3,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_mode,
    input  logic [CNT_W-1:0]  length,
    input  logic [3:0]        decim,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TRIG,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  length_q, length_d;
    logic [3:0]        decim_q, decim_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [3:0]        decim_cnt_q, decim_cnt_d;
    logic              vsync_prev_q, vsync_prev_d;
    logic              overflow_q, overflow_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;

    // FIFO storage: each entry carries the last marker above the sampled bus.
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DATA_W:0]   rd_word;

    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push_en;
    logic              take_sample;
    logic              vsync_active;
    logic              vsync_edge;
    logic              is_last;
    logic              final_sample;

    // The pointers carry one extra wrap bit, so equal pointers mean empty and
    // a difference only in the wrap bit means full.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && m_ready;

    // The vsync edge compares the current pin with the previous cycle's value.
    // The history register resets to the inactive level, so a bus that is
    // already active at the first cycle still counts as an assertion edge.
    assign vsync_active = (data_in[VSYNC_BIT] == VSYNC_POL);
    assign vsync_edge   = vsync_active && (vsync_prev_q != VSYNC_POL);

    assign is_last      = (sample_cnt_q == (length_q - CNT_ONE));
    assign final_sample = ((sample_cnt_q + CNT_ONE) == length_q);

    // Next-state logic. The sample decision is shared by WAIT_TRIG (trigger
    // cycle = sample 0) and CAPTURE (decimated samples). It is resolved after
    // the state case. Abort comes last so that it overrides everything else.
    always_comb begin
        state_d      = state_q;
        length_d     = length_q;
        decim_d      = decim_q;
        sample_cnt_d = sample_cnt_q;
        decim_cnt_d  = decim_cnt_q;
        overflow_d   = overflow_q;
        vsync_prev_d = data_in[VSYNC_BIT];
        take_sample  = 1'b0;
        push_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    length_d     = length;
                    decim_d      = decim;
                    overflow_d   = 1'b0;
                    sample_cnt_d = '0;
                    decim_cnt_d  = '0;
                    state_d      = (length == '0) ? ST_DONE : ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                if (!trig_mode || vsync_edge) begin
                    take_sample = 1'b1;
                    decim_cnt_d = '0;
                end
            end
            ST_CAPTURE: begin
                if (decim_cnt_q == decim_q) begin
                    take_sample = 1'b1;
                    decim_cnt_d = '0;
                end else begin
                    decim_cnt_d = decim_cnt_q + 4'd1;
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the FIFO is empty after this cycle's pop,
                // so that done follows the final pop by one cycle.
                if (fifo_empty || (pop && ((rd_ptr_q + PTR_ONE) == wr_ptr_q))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Fullness is judged before any same-cycle pop, so a push into a full
        // FIFO is always dropped. The sample still counts toward the length.
        if (take_sample) begin
            sample_cnt_d = sample_cnt_q + CNT_ONE;
            if (fifo_full) begin
                overflow_d = 1'b1;
            end else begin
                push_en = 1'b1;
            end
            state_d = final_sample ? ST_DRAIN : ST_CAPTURE;
        end

        wr_ptr_d = push_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop     ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        if (abort) begin
            state_d      = ST_IDLE;
            length_d     = length_q;
            decim_d      = decim_q;
            sample_cnt_d = '0;
            decim_cnt_d  = '0;
            overflow_d   = overflow_q;
            push_en      = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
        end
    end

    // Control registers and FIFO pointers. The reset returns the block to
    // idle, with an empty FIFO and the vsync history at the inactive level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            length_q     <= '0;
            decim_q      <= '0;
            sample_cnt_q <= '0;
            decim_cnt_q  <= '0;
            vsync_prev_q <= ~VSYNC_POL;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            length_q     <= length_d;
            decim_q      <= decim_d;
            sample_cnt_q <= sample_cnt_d;
            decim_cnt_q  <= decim_cnt_d;
            vsync_prev_q <= vsync_prev_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // FIFO storage has no reset. Stale contents never reach the port because
    // the outputs below are gated by m_valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {is_last, data_in};
        end
    end

    // The head entry is held until it is popped. A full FIFO refuses pushes,
    // so the head slot is never overwritten while it is valid.
    assign rd_word  = mem_q[rd_ptr_q[AW-1:0]];
    assign m_valid  = !fifo_empty;
    assign m_data   = m_valid ? rd_word[DATA_W-1:0] : '0;
    assign m_last   = m_valid & rd_word[DATA_W];
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign overflow = overflow_q;

endmodule
